// File: rtl/window_sum_pkg.sv
// Shared definitions for the moving-sum block: output width helper and a
// generic {valid, data} handshake record.
package window_pkg;

  localparam int rv_max_width_lp = 64;

  typedef struct packed {
    logic                       valid;
    logic [rv_max_width_lp-1:0] data;
  } rv_word_t;

  // Wide enough to hold delay copies of the largest width-bit sample.
  function automatic int sum_width(input int width, input int delay);
    return width + $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/window_sum_rv_pipe_reg.sv
// Single-entry ready/valid register: accepts whenever empty or draining,
// holds data and valid stable while the consumer stalls.
module rv_pipe_reg #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  logic               valid_q, valid_d;
  logic [width_p-1:0] data_q, data_d;
  logic               load;

  assign ready_o = ~valid_q | ready_i;
  assign load    = valid_i & ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/window_sum.sv
// Moving sum of the last delay_p samples from a (current, delayed) stream pair.
// One cycle from joined handshake to valid_o; both inputs stall while the output is held.
module window_sum
  import window_pkg::*;
#(
  parameter  int width_p      = 8,
  parameter  int delay_p      = 8,
  localparam int sum_width_lp = sum_width(width_p, delay_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [width_p-1:0]      cur_data_i,
  input  logic                    cur_valid_i,
  output logic                    cur_ready_o,
  input  logic [width_p-1:0]      dly_data_i,
  input  logic                    dly_valid_i,
  output logic                    dly_ready_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [sum_width_lp-1:0] data_o
);

  localparam int cnt_width_lp = $clog2(delay_p + 1);
  localparam int pad_lp       = sum_width_lp - width_p;

  logic                    slot_free;
  logic                    fire;
  logic                    warm;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [sum_width_lp-1:0] acc_q, acc_d;
  logic [sum_width_lp-1:0] cur_ext, dly_term;

  assign fire        = cur_valid_i & dly_valid_i & slot_free;
  assign cur_ready_o = slot_free & dly_valid_i;
  assign dly_ready_o = slot_free & cur_valid_i;

  // The delay line's first delay_p words are stale RAM, so they subtract nothing.
  assign warm     = (cnt_q == cnt_width_lp'(delay_p));
  assign cur_ext  = {{pad_lp{1'b0}}, cur_data_i};
  assign dly_term = warm ? {{pad_lp{1'b0}}, dly_data_i} : '0;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q + cur_ext - dly_term;
    if (fire && !warm) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (fire) begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  rv_pipe_reg #(
    .width_p (sum_width_lp)
  ) u_out (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (cur_valid_i & dly_valid_i),
    .data_i  (acc_d),
    .ready_o (slot_free),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

endmodule

// File: tb/tb_window_sum.sv
// Self-checking bench for window_sum (width 8, window 4): golden tables plus
// a transaction scoreboard checking handshakes, hold and ordering every cycle.
module tb_window_sum;

  localparam int W   = 8;
  localparam int DLY = 4;
  localparam int SW  = 11;
  localparam int MAX_CYC = 300;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [W-1:0]  cur_data_i, dly_data_i;
  logic          cur_valid_i, dly_valid_i, cur_ready_o, dly_ready_o;
  logic          valid_o, ready_i;
  logic [SW-1:0] data_o;

  window_sum #(.width_p(W), .delay_p(DLY)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .cur_data_i  (cur_data_i),
    .cur_valid_i (cur_valid_i),
    .cur_ready_o (cur_ready_o),
    .dly_data_i  (dly_data_i),
    .dly_valid_i (dly_valid_i),
    .dly_ready_o (dly_ready_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cur;
    int dly;
    int exp_sum;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int outs  = 0;
  int m_acc = 0;
  int m_cnt = 0;
  int cur_q[$];
  int dly_q[$];
  int exp_q[$];
  int gold_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive after the previous edge, check at negedge, update model at posedge.
  task automatic cycle(input bit ce, input bit de, input bit rdy);
    bit cv, dv, m_vld, m_free, m_fire, hs;
    int dterm;
    cv = ce && (cur_q.size() > 0);
    dv = de && (dly_q.size() > 0);
    cur_valid_i = cv;
    dly_valid_i = dv;
    cur_data_i  = cv ? W'(cur_q[0]) : '0;
    dly_data_i  = dv ? W'(dly_q[0]) : '0;
    ready_i     = rdy;
    @(negedge clk);
    m_vld  = (exp_q.size() > 0);
    m_free = !m_vld || rdy;
    m_fire = cv && dv && m_free;
    check("cur_ready_o", int'(cur_ready_o), int'(m_free && dv));
    check("dly_ready_o", int'(dly_ready_o), int'(m_free && cv));
    check("valid_o", int'(valid_o), int'(m_vld));
    if (m_vld) check("data_o", int'(data_o), exp_q[0]);
    hs = m_vld && rdy;
    if (hs && gold_q.size() > 0) check("golden", int'(data_o), gold_q.pop_front());
    @(posedge clk);
    if (hs) begin
      void'(exp_q.pop_front());
      outs++;
    end
    if (m_fire) begin
      dterm = (m_cnt == DLY) ? dly_q[0] : 0;
      m_acc = (m_acc + cur_q[0] - dterm) & ((1 << SW) - 1);
      if (m_cnt < DLY) m_cnt++;
      exp_q.push_back(m_acc);
      void'(cur_q.pop_front());
      void'(dly_q.pop_front());
    end
    #1;
  endtask

  // mode 0: free run; 1: stall after 3rd output; 2: dly skewed by 2; 3: ready toggles
  task automatic run_seq(input int mode, input int max_out);
    int cyc;
    bit ce, de, rdy;
    cyc  = 0;
    outs = 0;
    while ((cur_q.size() > 0 || exp_q.size() > 0) && outs < max_out && cyc < MAX_CYC) begin
      ce = 1'b1; de = 1'b1; rdy = 1'b1;
      case (mode)
        1: rdy = !(cyc >= 3 && cyc <= 5);
        2: de  = (cyc >= 2);
        3: rdy = (cyc % 2 == 0);
        default: ;
      endcase
      cycle(ce, de, rdy);
      cyc++;
    end
    check("run_in_budget", int'(cyc < MAX_CYC), 1);
    cur_valid_i = 1'b0;
    dly_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i     = 1'b1;
    cur_valid_i = 1'b0;
    dly_valid_i = 1'b0;
    ready_i     = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    cur_q.delete();
    dly_q.delete();
    exp_q.delete();
    gold_q.delete();
    @(negedge clk);
    check("valid_after_reset", int'(valid_o), 0);
    check("data_after_reset", int'(data_o), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_warmup();
    vec_t tbl[8];
    tbl[0] = '{1, 8'hFF, 1};  tbl[1] = '{2, 8'hFF, 3};
    tbl[2] = '{3, 8'hFF, 6};  tbl[3] = '{4, 8'hFF, 10};
    tbl[4] = '{5, 1, 14};     tbl[5] = '{6, 2, 18};
    tbl[6] = '{7, 3, 22};     tbl[7] = '{8, 4, 26};
    for (int i = 0; i < 8; i++) begin
      cur_q.push_back(tbl[i].cur);
      dly_q.push_back(tbl[i].dly);
      gold_q.push_back(tbl[i].exp_sum);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    cur_data_i = '0; dly_data_i = '0;
    cur_valid_i = 1'b0; dly_valid_i = 1'b0; ready_i = 1'b1;
    do_reset();

    // Warm-up with free-running output
    load_warmup();
    run_seq(0, 100);
    check("warmup_all_outputs", gold_q.size(), 0);

    // Backpressure while 6 is held
    do_reset();
    load_warmup();
    run_seq(1, 100);
    check("stall_all_outputs", gold_q.size(), 0);

    // Delayed stream arrives two cycles late
    do_reset();
    load_warmup();
    run_seq(2, 100);
    check("skew_all_outputs", gold_q.size(), 0);

    // Saturation: full-scale samples, no wrap
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cur_q.push_back(255);
      dly_q.push_back(255);
      gold_q.push_back(i < 4 ? 255 * (i + 1) : 1020);
    end
    run_seq(0, 100);
    check("sat_all_outputs", gold_q.size(), 0);

    // Mid-stream reset after 6 outputs, then restart with stale delayed words
    do_reset();
    load_warmup();
    run_seq(0, 6);
    check("pre_reset_outputs", outs, 6);
    do_reset();
    begin
      int g[5];
      int d[5];
      g = '{5, 10, 15, 20, 20};
      d = '{8'hAA, 8'h13, 8'h77, 8'hFF, 5};
      for (int i = 0; i < 5; i++) begin
        cur_q.push_back(5);
        dly_q.push_back(d[i]);
        gold_q.push_back(g[i]);
      end
    end
    run_seq(0, 100);
    check("restart_all_outputs", gold_q.size(), 0);

    // Ready toggling every cycle with continuous inputs
    do_reset();
    load_warmup();
    run_seq(3, 100);
    check("toggle_all_outputs", gold_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
